// File: rtl/sorteio_papeis_pkg.sv
// Shared definitions for the role-draw block: role and FSM-state encodings,
// LFSR reset constant and the LFSR feedback step.
package sorteio_papeis_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 16'hACE1;
  localparam logic [3:0] ESTADO_ILEGAL = 4'hF;

  typedef enum logic [1:0] {
    ALDEAO  = 2'd0,
    LOBO    = 2'd1,
    VIDENTE = 2'd2
  } papel_t;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    INICIA  = 3'd1,
    SORTEIA = 3'd2,
    TROCA   = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  // Fibonacci shift-left step, taps 15/13/12/10
  function automatic logic [LFSR_W-1:0] lfsr_passo(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/sorteio_papeis_if.sv
// Control/readout bundle between the game control unit and sorteio_papeis.
//   zera, e_seed, sortear : control strobes into the draw block
//   idx_leitura           : player index for role readout
//   papel                 : role of player idx_leitura
//   ocupado, pronto       : busy flag and completion pulse
//   db_estado             : debug view of the FSM state
interface sorteio_papeis_if
  import sorteio_papeis_pkg::*;
#(
  parameter int unsigned NUM_JOGADORES = 8
);
  localparam int unsigned IW = (NUM_JOGADORES > 1) ? $clog2(NUM_JOGADORES) : 1;

  logic          zera;
  logic          e_seed;
  logic          sortear;
  logic [IW-1:0] idx_leitura;
  papel_t        papel;
  logic          ocupado;
  logic          pronto;
  logic [3:0]    db_estado;

  modport master (
    output zera, e_seed, sortear, idx_leitura,
    input  papel, ocupado, pronto, db_estado
  );

  modport slave (
    input  zera, e_seed, sortear, idx_leitura,
    output papel, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/sorteio_papeis_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and step enable.
//   clock, reset : rising-edge clock, async active-high reset (-> 16'hACE1)
//   i_zera       : synchronous clear back to the reset constant
//   i_carrega    : load i_semente (a zero seed loads 16'hACE1 instead)
//   i_avanca     : advance one step
//   o_proximo    : value the register will hold after the next step
module lfsr16
  import sorteio_papeis_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_zera,
  input  logic              i_carrega,
  input  logic [LFSR_W-1:0] i_semente,
  input  logic              i_avanca,
  output logic [LFSR_W-1:0] o_proximo
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_proximo;

  assign w_proximo = lfsr_passo(r_lfsr);
  assign o_proximo = w_proximo;

  // All-zero is the LFSR lock-up state, so a zero seed is replaced
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_RESET;
    end else if (i_zera) begin
      r_lfsr <= LFSR_RESET;
    end else if (i_carrega) begin
      r_lfsr <= (i_semente == '0) ? LFSR_RESET : i_semente;
    end else if (i_avanca) begin
      r_lfsr <= w_proximo;
    end
  end

endmodule

// File: rtl/sorteio_papeis.sv
// Role draw for a werewolf-style game: fills a role table with NUM_LOBOS
// wolves (plus one seer when VIDENTE_EN is defined) and shuffles it with a
// Fisher-Yates pass driven by lfsr16, using rejection for out-of-range j.
// Optional feature macro: VIDENTE_EN.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : zera/e_seed/sortear/idx_leitura in,
//                  papel/ocupado/pronto/db_estado out
module sorteio_papeis
  import sorteio_papeis_pkg::*;
#(
  parameter int unsigned NUM_JOGADORES = 8,
  parameter int unsigned NUM_LOBOS     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  sorteio_papeis_if.slave       bus
);

  localparam int unsigned IW = (NUM_JOGADORES > 1) ? $clog2(NUM_JOGADORES) : 1;

  logic [LFSR_W-1:0] r_contador;
  estado_t           r_estado;
  papel_t            r_papeis [NUM_JOGADORES];
  logic [IW-1:0]     r_i;
  logic [IW-1:0]     r_j;
  logic              r_ocupado;
  logic              r_pronto;

  logic [LFSR_W-1:0] w_lfsr_prox;
  logic [IW-1:0]     w_j;
  logic              w_carrega;
  logic              w_avanca;
  papel_t            w_papel;
  logic [3:0]        w_db_estado;

  // Seed capture only while idle; strobes during a draw are ignored
  assign w_carrega = bus.e_seed && (r_estado == OCIOSO);
  assign w_avanca  = (r_estado == SORTEIA);
  assign w_j       = w_lfsr_prox[IW-1:0];

  lfsr16 u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .i_zera    (bus.zera),
    .i_carrega (w_carrega),
    .i_semente (r_contador),
    .i_avanca  (w_avanca),
    .o_proximo (w_lfsr_prox)
  );

  // Free-running seed source
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contador <= '0;
    end else if (bus.zera) begin
      r_contador <= '0;
    end else begin
      r_contador <= r_contador + 16'd1;
    end
  end

  // Draw FSM; ocupado/pronto are registered alongside each transition
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_i       <= '0;
      r_j       <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
      for (int unsigned k = 0; k < NUM_JOGADORES; k++) r_papeis[k] <= ALDEAO;
    end else if (bus.zera) begin
      r_estado  <= OCIOSO;
      r_i       <= '0;
      r_j       <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
      for (int unsigned k = 0; k < NUM_JOGADORES; k++) r_papeis[k] <= ALDEAO;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (bus.sortear) begin
            r_estado  <= INICIA;
            r_ocupado <= 1'b1;
          end
        end
        INICIA: begin
          for (int unsigned k = 0; k < NUM_JOGADORES; k++) begin
            if (k < NUM_LOBOS) r_papeis[k] <= LOBO;
            else               r_papeis[k] <= ALDEAO;
          end
`ifdef VIDENTE_EN
          r_papeis[NUM_LOBOS] <= VIDENTE;
`endif
          r_i      <= IW'(NUM_JOGADORES - 1);
          r_estado <= SORTEIA;
        end
        SORTEIA: begin
          // j beyond i is rejected and redrawn on the next step
          if (w_j <= r_i) begin
            r_j      <= w_j;
            r_estado <= TROCA;
          end
        end
        TROCA: begin
          r_papeis[r_i] <= r_papeis[r_j];
          r_papeis[r_j] <= r_papeis[r_i];
          r_estado      <= PROXIMO;
        end
        PROXIMO: begin
          if (r_i == IW'(1)) begin
            r_estado <= FIM;
            r_pronto <= 1'b1;
          end else begin
            r_i      <= r_i - IW'(1);
            r_estado <= SORTEIA;
          end
        end
        FIM: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  // Role readout; indices past the last player read as ALDEAO
  if (NUM_JOGADORES == (1 << IW)) begin : g_leitura_cheia
    always_comb w_papel = r_papeis[bus.idx_leitura];
  end else begin : g_leitura_parcial
    always_comb begin
      w_papel = ALDEAO;
      if ({1'b0, bus.idx_leitura} < (IW+1)'(NUM_JOGADORES))
        w_papel = r_papeis[bus.idx_leitura];
    end
  end

  // Debug state code; unreachable encodings report 4'hF
  always_comb begin
    w_db_estado = ESTADO_ILEGAL;
    case (r_estado)
      OCIOSO, INICIA, SORTEIA, TROCA, PROXIMO, FIM: w_db_estado = {1'b0, r_estado};
      default: w_db_estado = ESTADO_ILEGAL;
    endcase
  end

  assign bus.papel     = w_papel;
  assign bus.ocupado   = r_ocupado;
  assign bus.pronto    = r_pronto;
  assign bus.db_estado = w_db_estado;

endmodule

// File: tb/tb_sorteio_papeis.sv
// Scoreboard bench for sorteio_papeis: stimulus pushes the reference table of
// each draw, a monitor pops and compares it whenever pronto pulses.
module tb_sorteio_papeis;
  import sorteio_papeis_pkg::*;

  localparam int NJ = 8;
  localparam int NL = 2;
  localparam int IW = $clog2(NJ);
`ifdef VIDENTE_EN
  localparam int NV = 1;
`else
  localparam int NV = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #20 clock = ~clock;

  sorteio_papeis_if #(.NUM_JOGADORES(NJ)) bus();

  sorteio_papeis #(.NUM_JOGADORES(NJ), .NUM_LOBOS(NL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_pronto = 0;
  int            n_issued = 0;
  logic [31:0]   q_esp[$];
  logic [15:0]   m_lfsr;
  logic [15:0]   m_cnt;
  logic          sel_stim;
  logic [IW-1:0] idx_stim;
  logic [IW-1:0] idx_mon;
  logic [31:0]   mon_tab;
  int            mon_nl;
  int            mon_nv;

  assign bus.idx_leitura = sel_stim ? idx_stim : idx_mon;

  // Reference seed counter: counts clocks since reset/zera
  always @(posedge clock or posedge reset) begin
    if (reset)         m_cnt <= 16'd0;
    else if (bus.zera) m_cnt <= 16'd0;
    else               m_cnt <= m_cnt + 16'd1;
  end

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] esp);
    n_cmp++;
    if (act !== esp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nome, act, esp);
    end
  endtask

  function automatic logic [15:0] passo(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return (16'(v << 1)) | {15'd0, fb};
  endfunction

  // Reference shuffle: initial fill then Fisher-Yates with rejection
  task automatic modelo_sorteio(output logic [31:0] tab);
    int r[NJ];
    int j;
    int tmp;
    for (int k = 0; k < NJ; k++) r[k] = (k < NL) ? 1 : 0;
    if (NV == 1) r[NL] = 2;
    for (int i = NJ - 1; i >= 1; i--) begin
      do begin
        m_lfsr = passo(m_lfsr);
        j = int'(m_lfsr) % (1 << IW);
      end while (j > i);
      tmp = r[i]; r[i] = r[j]; r[j] = tmp;
    end
    tab = '0;
    for (int k = 0; k < NJ; k++) tab[2*k +: 2] = 2'(r[k]);
  endtask

  // Monitor: on every pronto pulse read the table and check it
  always @(negedge clock) begin
    if (bus.pronto === 1'b1) begin
      n_pronto++;
      mon_tab = '0;
      mon_nl = 0;
      mon_nv = 0;
      for (int k = 0; k < NJ; k++) begin
        idx_mon = IW'(k);
        #1;
        mon_tab[2*k +: 2] = bus.papel;
        if (bus.papel == LOBO)    mon_nl++;
        if (bus.papel == VIDENTE) mon_nv++;
      end
      chk("fila_em_pronto", 32'(q_esp.size() > 0), 32'd1);
      if (q_esp.size() > 0) chk("tabela", mon_tab, q_esp.pop_front());
      chk("qtd_lobos", 32'(mon_nl), 32'(NL));
      chk("qtd_videntes", 32'(mon_nv), 32'(NV));
      chk("ocupado_em_pronto", 32'(bus.ocupado), 32'd1);
    end
  end

  task automatic le_tabela(output logic [31:0] t);
    t = '0;
    sel_stim = 1'b1;
    for (int k = 0; k < NJ; k++) begin
      idx_stim = IW'(k);
      #1;
      t[2*k +: 2] = bus.papel;
    end
    sel_stim = 1'b0;
  endtask

  // Called at a negedge while idle
  task automatic captura_semente();
    m_lfsr = (m_cnt == 16'd0) ? 16'hACE1 : m_cnt;
  endtask

  task automatic inicia(input bit com_semente);
    logic [31:0] t;
    if (com_semente) begin
      bus.e_seed = 1'b1;
      captura_semente();
    end
    bus.sortear = 1'b1;
    modelo_sorteio(t);
    q_esp.push_back(t);
    n_issued++;
    @(negedge clock);
    bus.sortear = 1'b0;
    bus.e_seed  = 1'b0;
  endtask

  task automatic so_semente();
    bus.e_seed = 1'b1;
    captura_semente();
    @(negedge clock);
    bus.e_seed = 1'b0;
  endtask

  task automatic espera_pronto();
    int c = 0;
    while (bus.pronto !== 1'b1 && c < 256) begin
      @(negedge clock);
      c++;
    end
    chk("pronto_em_256", 32'(bus.pronto), 32'd1);
    @(negedge clock);
    chk("pronto_um_ciclo", 32'(bus.pronto), 32'd0);
    chk("ocioso_apos_fim", 32'(bus.db_estado), 32'd0);
  endtask

  task automatic espera_estado(input logic [3:0] e, input string nome);
    int c = 0;
    while (bus.db_estado !== e && c < 256) begin
      @(negedge clock);
      c++;
    end
    chk(nome, 32'(bus.db_estado), 32'(e));
  endtask

  task automatic pulsa_zera();
    bus.zera = 1'b1;
    @(negedge clock);
    bus.zera = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  initial begin
    logic [31:0] t;
    int c;
    int modo;
    reset = 1'b1;
    bus.zera = 1'b0;
    bus.e_seed = 1'b0;
    bus.sortear = 1'b0;
    sel_stim = 1'b0;
    idx_stim = '0;
    idx_mon = '0;
    m_lfsr = 16'hACE1;
    repeat (2) @(negedge clock);

    // Reset state
    chk("reset_estado", 32'(bus.db_estado), 32'd0);
    chk("reset_ocupado", 32'(bus.ocupado), 32'd0);
    chk("reset_pronto", 32'(bus.pronto), 32'd0);
    le_tabela(t);
    chk("reset_tabela", t, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Draw from the reset LFSR, no seed capture
    inicia(1'b0);
    chk("ocupado_durante", 32'(bus.ocupado), 32'd1);
    espera_pronto();

    // Seed captured at counter 0 behaves as 16'hACE1
    pulsa_zera();
    inicia(1'b1);
    espera_pronto();

    // Two draws seeded at counter 16'h1234
    for (int r = 0; r < 2; r++) begin
      pulsa_zera();
      c = 0;
      while (m_cnt != 16'h1234 && c < 6000) begin
        @(negedge clock);
        c++;
      end
      chk("contador_1234", 32'(m_cnt), 32'h1234);
      inicia(1'b1);
      espera_pronto();
    end

    // sortear/e_seed repeated mid-draw are ignored
    inicia(1'b0);
    espera_estado(4'd2, "chega_sorteia");
    bus.sortear = 1'b1;
    bus.e_seed  = 1'b1;
    @(negedge clock);
    bus.sortear = 1'b0;
    bus.e_seed  = 1'b0;
    espera_pronto();

    // zera during TROCA aborts the draw without a pronto pulse
    bus.sortear = 1'b1;
    @(negedge clock);
    bus.sortear = 1'b0;
    espera_estado(4'd3, "chega_troca");
    pulsa_zera();
    chk("zera_estado", 32'(bus.db_estado), 32'd0);
    chk("zera_ocupado", 32'(bus.ocupado), 32'd0);
    chk("zera_pronto", 32'(bus.pronto), 32'd0);
    le_tabela(t);
    chk("zera_tabela", t, 32'd0);
    repeat (3) @(negedge clock);

    // Randomised seeds and seeding styles
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 30)) @(negedge clock);
      modo = int'($urandom_range(0, 2));
      if (modo == 0) begin
        inicia(1'b1);
      end else if (modo == 1) begin
        so_semente();
        repeat ($urandom_range(0, 5)) @(negedge clock);
        inicia(1'b0);
      end else begin
        inicia(1'b0);
      end
      espera_pronto();
    end

    repeat (4) @(negedge clock);
    chk("total_pronto", 32'(n_pronto), 32'(n_issued));
    chk("fila_vazia", 32'(q_esp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sorteio_papeis.md
SORTEIO_PAPEIS -- requirements
Module: sorteio_papeis

Interface
REQ-001 Parameter NUM_JOGADORES, default 8, number of players (2..16).
REQ-002 Parameter NUM_LOBOS, default 2, number of wolf roles (1..NUM_JOGADORES-1).
REQ-003 Ports: clock and reset. reset is asynchronous and active-high. clock is the rising-edge system clock.
REQ-004 zera  in  1  sync clear from the game control unit's zera_CS.
REQ-005 e_seed  in  1  one-cycle seed-capture strobe from the game control unit's e_seed_reg.
REQ-006 sortear  in  1  start pulse; triggers one role draw.
REQ-007 idx_leitura  in  $clog2(NUM_JOGADORES)  player index for role readout.
REQ-008 papel  out  2  role of player idx_leitura: 0 ALDEAO, 1 LOBO, 2 VIDENTE.
REQ-009 ocupado  out  1  draw in progress.
REQ-010 pronto  out  1  one-cycle pulse when the draw completes.
REQ-011 db_estado  out  4  current FSM state code; 4'hF for an illegal state.

Function
REQ-012 16-bit seed counter: free-running, +1 every clock, wraps at 16'hFFFF.
REQ-013 e_seed in OCIOSO: the counter value loads into the 16-bit LFSR. A captured value of 0 loads 16'hACE1 instead.
REQ-014 LFSR: Fibonacci, shift left. Feedback = bit15^bit13^bit12^bit10. Advances only in state SORTEIA.
REQ-015 FSM states and transitions:
- OCIOSO(0) -> INICIA(1) on sortear.
- INICIA: role table fills with NUM_LOBOS LOBO entries at indices 0.., then ALDEAO; i set to NUM_JOGADORES-1. -> SORTEIA.
- SORTEIA(2): LFSR steps; j = low $clog2(NUM_JOGADORES) bits of the new LFSR value. j>i stays in SORTEIA (rejection); else -> TROCA.
- TROCA(3): swap roles[i] and roles[j]. -> PROXIMO.
- PROXIMO(4): i==1 -> FIM; else i-1 -> SORTEIA.
- FIM(5): pronto=1 for one cycle. -> OCIOSO.
REQ-016 ocupado=1 in every state except OCIOSO.
REQ-017 sortear or e_seed while ocupado=1 is ignored.
REQ-018 sortear and e_seed in the same OCIOSO cycle: the seed captures and the draw starts; the first SORTEIA step uses the new seed.
REQ-019 sortear with no prior e_seed: the draw uses the current LFSR contents (16'hACE1 after reset).
REQ-020 papel is combinational from the role table and idx_leitura.
- papel reads the table at any time; mid-draw values are unspecified.
- idx_leitura >= NUM_JOGADORES returns 0.
REQ-021 After FIM the table is a permutation of the initial fill:
- exactly NUM_LOBOS LOBO entries;
- at most one VIDENTE entry.
REQ-022 Same seed + same sortear timing gives an identical table (deterministic).

Reset
REQ-023 Async reset: FSM=OCIOSO, LFSR=16'hACE1, seed counter=0, all roles=ALDEAO, ocupado=0, pronto=0.
REQ-024 zera=1 at a clock edge has the same effect as reset, from any state. This includes mid-draw: no pronto pulse is issued. zera has priority over sortear and e_seed.

Configuration
REQ-025 Macro VIDENTE_EN.
- Defined: INICIA sets roles[NUM_LOBOS]=VIDENTE, and the final table holds exactly one VIDENTE.
- Undefined: no VIDENTE is ever produced, and papel never equals 2.

Structure
REQ-026 A shared package holds:
- role enum: ALDEAO=2'd0, LOBO=2'd1, VIDENTE=2'd2;
- FSM state constants;
- LFSR reset constant 16'hACE1.
REQ-027 The LFSR with seed load and step enable SHALL be the sub-module lfsr16.

Verification
REQ-028 Reset, then sortear with no e_seed. Required: pronto within 256 cycles; table has 2 LOBO, 1 VIDENTE (VIDENTE_EN defined), 5 ALDEAO.
REQ-029 e_seed at seed counter 16'h0000. Required: LFSR=16'hACE1. Result matches a draw seeded directly with 16'hACE1.
REQ-030 Two draws, both with e_seed at counter 16'h1234. Required: identical role tables.
REQ-031 zera during TROCA. Required: next cycle db_estado=0, ocupado=0, all papel=0, no pronto pulse.
REQ-032 sortear pulsed again during SORTEIA. Required: ignored; exactly one pronto pulse.
REQ-033 VIDENTE_EN undefined, 100 random seeds. Required: every table has NUM_LOBOS LOBO entries and no VIDENTE.
